axi_regbridge: RTL and testbench
================================

Name: axi_regbridge

Overview:
- AXI4-Lite slave that converts CPU register accesses from the PS general-purpose port into the single-outstanding armreq/armack register bus.
- Sits directly upstream of the register bank and drives its armaddr/armwdata/armwr/armwstrb/armreq inputs.
- Returns armrdata/armerr as AXI R/B responses.
- Serialises reads and writes. Guarantees the clean armreq rising edge the register bank needs to detect each request.

Parameters:
- TIMEOUT, 1024: cycles to wait for armack before synthesising an error response (optional feature only).
- TOW, 16: width of the timeout counter; 2^TOW must exceed TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- awaddr/awvalid/awready  in/in/out  32/1/1  AXI write address channel.
- wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  AXI write data channel.
- bresp/bvalid/bready  out/out/in  2/1/1  AXI write response channel.
- araddr/arvalid/arready  in/in/out  32/1/1  AXI read address channel.
- rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  AXI read data channel.
- armaddr  out  32  register bus address.
- armwdata  out  32  register bus write data.
- armwstrb  out  4  register bus byte strobes.
- armwr  out  1  1 = write, 0 = read.
- armreq  out  1  request, level held until armack.
- armack  in  1  one-cycle completion pulse.
- armrdata  in  32  read data, valid with armack.
- armerr  in  1  error flag, valid with armack.

Behaviour:
- Reset (async assert, sync release) values:
  - all ready/valid outputs 0, armreq 0, armwr 0;
  - armaddr, armwdata, rdata 0; armwstrb 0; bresp and rresp 2'b00;
  - state IDLE; pending-write flags clear; lastrd = 1, so the first arbitration favours write.
- Write capture:
  - awready is high in IDLE while AW is not yet held; wready is high in IDLE while W is not yet held.
  - AW and W are accepted independently, in either order, and latched with held flags.
  - A write is eligible once both flags are set.
- Read capture: arready is high only in IDLE when no write is eligible, or when read wins arbitration. The AR handshake starts the read immediately.
- Arbitration (IDLE, write eligible and arvalid in the same cycle):
  - the channel not served last wins; lastrd toggles per grant.
  - The loser keeps its latched or pending state.
- States:
  - IDLE -> REQ on a grant. In that cycle, load armaddr/armwdata/armwstrb/armwr and set armreq = 1 from the next edge.
    - Reads: armwstrb = 0, armwdata unchanged.
  - REQ: armreq held 1. On armack:
    - armreq <= 0, go to RESP.
    - Capture armrdata into rdata (reads). Set resp = armerr ? 2'b10 (SLVERR) : 2'b00.
  - RESP: bvalid (write) or rvalid (read) = 1 and held until bready/rready.
    - Handshake -> IDLE and clear the held flags of that write.
    - Minimum REQ->RESP->IDLE path is 2 cycles, so armreq is low at least 2 cycles between requests.
- Latency: AXI handshake to armreq = 1 cycle; armack to valid response = 1 cycle.
- Only one transaction is outstanding; no new armreq while a response is unacknowledged.
- armack seen outside REQ is ignored and is not an error.
- Reset mid-REQ: armreq drops immediately (async); the transaction is discarded and no response is issued.

Optional Feature:
- AXI_REGBRIDGE_TIMEOUT_EN defined:
  - a TOW-bit counter clears on entry to REQ and increments each REQ cycle.
  - At count == TIMEOUT-1 without armack: armreq <= 0, go to RESP with resp = SLVERR and rdata = 32'hDEADDEAD.
  - A later stray armack is ignored.
  - Needed because the register bank never acks unmapped addresses.
- Undefined: REQ waits indefinitely for armack; the counter logic is absent.

Decomposition:
- Package axi_regbridge_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the state encoding (IDLE, REQ, RESP);
  - TIMEOUT_RDATA = 32'hDEADDEAD.
- No sub-module; the block is a single FSM with capture registers.

Test Plan:
- Write 0x00000008 <= 0x12345678, wstrb F, W presented 3 cycles before AW:
  - armreq rises 1 cycle after AW handshake with armwr = 1, armaddr = 0x8;
  - ack 2 cycles later -> bvalid, bresp = 00.
- Read 0x00000004, armrdata = 0xCAFEF00D with armack: rdata = 0xCAFEF00D, rresp = 00 one cycle later; armwstrb = 0 during REQ.
- AUX read with armerr = 1 on ack -> rresp = 10. Hold rready low 5 cycles -> rvalid and rdata stable, no new armreq.
- Eligible write and arvalid in the same cycle just after reset:
  - write is issued first, then read; armreq is low for at least 2 cycles between them;
  - next contention is granted to write.
- With AXI_REGBRIDGE_TIMEOUT_EN, TIMEOUT = 16, write to unmapped 0x00000070, no ack:
  - armreq drops after 16 cycles, bresp = 10;
  - stray armack 3 cycles later is ignored.
- Assert rst while in REQ -> armreq = 0 in the same cycle, no bvalid/rvalid; after release, a fresh read completes normally.

Source files
------------

// File: rtl/axi_regbridge_pkg.sv
// axi_regbridge shared constants: response codes, FSM encoding,
// and the read data returned when a request times out.
package axi_regbridge_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADDEAD;

endpackage

// File: rtl/axi_regbridge.sv
// AXI4-Lite slave -> single-outstanding armreq/armack register bus.
// Ports: clk, rst (async high); AXI AW/W/B/AR/R; arm* register bus.
// Optional: define AXI_REGBRIDGE_TIMEOUT_EN to error out unacked requests.
module axi_regbridge
   import axi_regbridge_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int TOW     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] armaddr,
   output logic [31:0] armwdata,
   output logic [3:0]  armwstrb,
   output logic        armwr,
   output logic        armreq,
   input  logic        armack,
   input  logic [31:0] armrdata,
   input  logic        armerr
);

   if (TIMEOUT >= (1 << TOW)) begin : g_tow_check
      $error("TOW too narrow for TIMEOUT");
   end

   logic [1:0]  state;
   logic        aw_held, w_held, lastrd;
   logic [31:0] aw_q, w_q;
   logic [3:0]  ws_q;
   logic [1:0]  resp_q;
   logic        idle, aw_hs, w_hs, wr_elig;
   logic        rd_go, wr_go, rsp_hs, tmo;

   assign idle    = (state == ST_IDLE);
   assign awready = idle & ~aw_held & ~rst;
   assign wready  = idle & ~w_held & ~rst;
   assign aw_hs   = awvalid & awready;
   assign w_hs    = wvalid & wready;

   // A handshake in this cycle counts toward eligibility so a write
   // reaches armreq one cycle after its last AXI handshake.
   assign wr_elig = idle & (aw_held | aw_hs) & (w_held | w_hs);
   // Read is offered when no write competes or when the write went last.
   assign arready = idle & ~rst & (~wr_elig | ~lastrd);
   assign rd_go   = arvalid & arready;
   assign wr_go   = wr_elig & ~rd_go;

   assign bvalid = (state == ST_RESP) & armwr;
   assign rvalid = (state == ST_RESP) & ~armwr;
   assign bresp  = resp_q;
   assign rresp  = resp_q;
   assign rsp_hs = (bvalid & bready) | (rvalid & rready);

`ifdef AXI_REGBRIDGE_TIMEOUT_EN
   logic [TOW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (wr_go | rd_go) begin
         cnt <= '0;
      end else if (state == ST_REQ) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tmo = (state == ST_REQ) & ~armack &
                (cnt == TOW'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         lastrd   <= 1'b1;
         aw_q     <= '0;
         w_q      <= '0;
         ws_q     <= '0;
         resp_q   <= RESP_OKAY;
         rdata    <= '0;
         armaddr  <= '0;
         armwdata <= '0;
         armwstrb <= '0;
         armwr    <= 1'b0;
         armreq   <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_q    <= awaddr;
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_q    <= wdata;
            ws_q   <= wstrb;
         end
         case (state)
            ST_IDLE: begin
               if (wr_go) begin
                  state    <= ST_REQ;
                  armreq   <= 1'b1;
                  armwr    <= 1'b1;
                  armaddr  <= aw_held ? aw_q : awaddr;
                  armwdata <= w_held ? w_q : wdata;
                  armwstrb <= w_held ? ws_q : wstrb;
                  lastrd   <= 1'b0;
               end else if (rd_go) begin
                  state    <= ST_REQ;
                  armreq   <= 1'b1;
                  armwr    <= 1'b0;
                  armaddr  <= araddr;
                  armwstrb <= 4'h0;
                  lastrd   <= 1'b1;
               end
            end
            ST_REQ: begin
               if (armack) begin
                  armreq <= 1'b0;
                  state  <= ST_RESP;
                  resp_q <= armerr ? RESP_SLVERR : RESP_OKAY;
                  if (!armwr) rdata <= armrdata;
               end else if (tmo) begin
                  armreq <= 1'b0;
                  state  <= ST_RESP;
                  resp_q <= RESP_SLVERR;
                  rdata  <= TIMEOUT_RDATA;
               end
            end
            ST_RESP: begin
               if (rsp_hs) begin
                  state <= ST_IDLE;
                  if (armwr) begin
                     aw_held <= 1'b0;
                     w_held  <= 1'b0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_regbridge.sv
// Directed bench for axi_regbridge: table of transactions plus
// hand sequences for arbitration, timeout and mid-request reset.
module tb_axi_regbridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0, armrdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic        bready = 1'b0, rready = 1'b0;
   logic        armack = 1'b0, armerr = 1'b0;
   logic        awready, wready, arready, bvalid, rvalid;
   logic        armwr, armreq;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, armaddr, armwdata;
   logic [3:0]  armwstrb;

   axi_regbridge #(.TIMEOUT(16), .TOW(16)) dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .armaddr(armaddr), .armwdata(armwdata), .armwstrb(armwstrb),
      .armwr(armwr), .armreq(armreq), .armack(armack),
      .armrdata(armrdata), .armerr(armerr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  strb;
      int          dly;
      logic [31:0] ackd;
      logic        err;
      logic [1:0]  resp;
      logic [31:0] rd;
      int          hold;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t tv[6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic expire(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   // ch 0 = AW, 1 = W, 2 = AR
   task automatic send(input int ch, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      case (ch)
         0: begin awaddr = a; awvalid = 1'b1; end
         1: begin wdata = d; wstrb = s; wvalid = 1'b1; end
         default: begin araddr = a; arvalid = 1'b1; end
      endcase
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         ok = (ch == 0) ? awready : (ch == 1) ? wready : arready;
         if (ok) @(posedge clk);
         else @(negedge clk);
      end
      #1;
      case (ch)
         0: awvalid = 1'b0;
         1: wvalid = 1'b0;
         default: arvalid = 1'b0;
      endcase
      if (!ok) expire("handshake");
   endtask

   task automatic serve(input vec_t v);
      @(negedge clk);
      for (int n = 0; n < 20 && !armreq; n++) @(negedge clk);
      if (!armreq) begin
         expire("armreq_wait");
         return;
      end
      chk("armwr", armwr, v.wr);
      chk("armaddr", armaddr, v.addr);
      chk("armwstrb", armwstrb, v.wr ? v.strb : 4'h0);
      if (v.wr) chk("armwdata", armwdata, v.wd);
      repeat (v.dly) @(negedge clk);
      armack = 1'b1;
      armrdata = v.ackd;
      armerr = v.err;
      @(negedge clk);
      armack = 1'b0;
      armerr = 1'b0;
      armrdata = 32'h0;
      chk("armreq_drop", armreq, 1'b0);
      for (int h = 0; h <= v.hold; h++) begin
         if (h > 0) @(negedge clk);
         if (v.wr) begin
            chk("bvalid", bvalid, 1'b1);
            chk("bresp", bresp, v.resp);
         end else begin
            chk("rvalid", rvalid, 1'b1);
            chk("rresp", rresp, v.resp);
            chk("rdata", rdata, v.rd);
         end
         if (h > 0) chk("hold_armreq", armreq, 1'b0);
      end
      if (v.wr) bready = 1'b1;
      else rready = 1'b1;
      @(posedge clk);
      #1;
      bready = 1'b0;
      rready = 1'b0;
   endtask

   task automatic contend(input vec_t w, input vec_t r,
                          input logic rd_first);
      int low;
      @(negedge clk);
      awaddr = w.addr; wdata = w.wd; wstrb = w.strb;
      araddr = r.addr;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      #1;
      chk("arb_arready", arready, rd_first);
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      wvalid = 1'b0;
      if (rd_first) arvalid = 1'b0;
      serve(rd_first ? r : w);
      low = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (armreq) break;
         low++;
      end
      chk("req_gap_ge2", (low >= 2), 1'b1);
      arvalid = 1'b0;
      serve(rd_first ? w : r);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      //          wr    addr   wdata         strb dly ackdata       err resp   rdata         hold
      tv[0] = '{1'b0, 32'h4,  32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0, 2'b00, 32'hCAFEF00D, 0};
      tv[1] = '{1'b0, 32'h20, 32'h0,        4'h0, 1, 32'h0BADBEEF, 1'b1, 2'b10, 32'h0BADBEEF, 5};
      tv[2] = '{1'b1, 32'h10, 32'hA5A5A5A5, 4'h5, 0, 32'h0,        1'b1, 2'b10, 32'h0,        0};
      tv[3] = '{1'b1, 32'h0,  32'hFFFFFFFF, 4'h8, 3, 32'h0,        1'b0, 2'b00, 32'h0,        2};
      tv[4] = '{1'b0, 32'hC,  32'h0,        4'h0, 2, 32'h11112222, 1'b0, 2'b00, 32'h11112222, 0};
      tv[5] = '{1'b1, 32'h3C, 32'h00C0FFEE, 4'h3, 1, 32'h0,        1'b0, 2'b00, 32'h0,        0};

      repeat (2) @(negedge clk);
      chk("rst_awready", awready, 1'b0);
      chk("rst_wready", wready, 1'b0);
      chk("rst_arready", arready, 1'b0);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_armreq", armreq, 1'b0);
      chk("rst_armwr", armwr, 1'b0);
      chk("rst_armaddr", armaddr, 32'h0);
      chk("rst_armwdata", armwdata, 32'h0);
      chk("rst_armwstrb", armwstrb, 4'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_bresp", bresp, 2'b00);
      chk("rst_rresp", rresp, 2'b00);
      rst = 1'b0;

      // Contention right after reset: write first, then write again.
      contend('{1'b1, 32'h30, 32'h01020304, 4'hF, 1, 32'h0, 1'b0, 2'b00, 32'h0, 0},
              '{1'b0, 32'h34, 32'h0, 4'h0, 0, 32'h55AA55AA, 1'b0, 2'b00, 32'h55AA55AA, 0},
              1'b0);
      contend('{1'b1, 32'h38, 32'h0A0B0C0D, 4'h6, 0, 32'h0, 1'b1, 2'b10, 32'h0, 0},
              '{1'b0, 32'h44, 32'h0, 4'h0, 1, 32'h76543210, 1'b0, 2'b00, 32'h76543210, 0},
              1'b0);

      // W leads AW by three cycles.
      send(1, 32'h0, 32'h12345678, 4'hF);
      repeat (2) begin
         @(negedge clk);
         chk("w_only_no_req", armreq, 1'b0);
      end
      send(0, 32'h8, 32'h0, 4'h0);
      chk("aw_to_req_1cyc", armreq, 1'b1);
      serve('{1'b1, 32'h8, 32'h12345678, 4'hF, 2, 32'h0, 1'b0, 2'b00, 32'h0, 0});

      // Last grant was a write, so read wins; the write stays latched.
      contend('{1'b1, 32'h48, 32'h99887766, 4'hC, 0, 32'h0, 1'b0, 2'b00, 32'h0, 0},
              '{1'b0, 32'h4C, 32'h0, 4'h0, 0, 32'h13572468, 1'b1, 2'b10, 32'h13572468, 0},
              1'b1);

      for (int i = 0; i < 6; i++) begin
         if (tv[i].wr) begin
            send(1, 32'h0, tv[i].wd, tv[i].strb);
            send(0, tv[i].addr, 32'h0, 4'h0);
         end else begin
            send(2, tv[i].addr, 32'h0, 4'h0);
         end
         serve(tv[i]);
      end

      // Stray ack while idle.
      @(negedge clk);
      armack = 1'b1;
      @(negedge clk);
      armack = 1'b0;
      chk("stray_bvalid", bvalid, 1'b0);
      chk("stray_rvalid", rvalid, 1'b0);
      chk("stray_armreq", armreq, 1'b0);

`ifdef AXI_REGBRIDGE_TIMEOUT_EN
      begin
         int hi;
         send(1, 32'h0, 32'h0000BEEF, 4'hF);
         send(0, 32'h70, 32'h0, 4'h0);
         hi = 0;
         @(negedge clk);
         for (int i = 0; i < 40; i++) begin
            if (!armreq) break;
            hi++;
            @(negedge clk);
         end
         chk("tmo_req_cycles", hi, 16);
         chk("tmo_bvalid", bvalid, 1'b1);
         chk("tmo_bresp", bresp, 2'b10);
         bready = 1'b1;
         @(posedge clk);
         #1;
         bready = 1'b0;
         repeat (3) @(negedge clk);
         armack = 1'b1;
         @(negedge clk);
         armack = 1'b0;
         chk("tmo_stray_bvalid", bvalid, 1'b0);
         chk("tmo_stray_armreq", armreq, 1'b0);
         send(2, 32'h74, 32'h0, 4'h0);
         for (int i = 0; i < 40 && !rvalid; i++) @(negedge clk);
         chk("tmo_rvalid", rvalid, 1'b1);
         chk("tmo_rdata", rdata, 32'hDEADDEAD);
         chk("tmo_rresp", rresp, 2'b10);
         rready = 1'b1;
         @(posedge clk);
         #1;
         rready = 1'b0;
      end
`endif

      // Reset while a read is in REQ.
      send(2, 32'h40, 32'h0, 4'h0);
      @(negedge clk);
      chk("pre_rst_armreq", armreq, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_mid_armreq", armreq, 1'b0);
      chk("rst_mid_rvalid", rvalid, 1'b0);
      chk("rst_mid_bvalid", bvalid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_rvalid", rvalid, 1'b0);
         chk("post_rst_armreq", armreq, 1'b0);
      end
      send(2, 32'h40, 32'h0, 4'h0);
      serve('{1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h600DCAFE, 1'b0, 2'b00, 32'h600DCAFE, 0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
